// File: rtl/pwl_activation_pipe_pkg.sv
// Shared fixed-point types, constants and the saturation helper for the
// piecewise-linear activation pipeline.
package pwl_activation_pipe_pkg;

  localparam int Q_INT         = 8;
  localparam int Q_FRAC        = 8;
  localparam int Q_SIZE        = Q_INT + Q_FRAC;
  localparam int ACT_SEG_BITS  = 4;
  localparam int ACT_BANK_BITS = 2;
  localparam int ACC_W         = 2 * Q_SIZE + 1;

  typedef logic signed [Q_SIZE-1:0] q_t;

  typedef struct packed {
    q_t slope;
    q_t icpt;
  } act_entry_t;

  typedef struct packed {
    logic sat;
    q_t   q;
  } sat_res_t;

  localparam q_t Q_MAX = {1'b0, {(Q_SIZE-1){1'b1}}};
  localparam q_t Q_MIN = {1'b1, {(Q_SIZE-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_QMAX = {{(ACC_W-Q_SIZE){1'b0}}, Q_MAX};
  localparam logic signed [ACC_W-1:0] ACC_QMIN = {{(ACC_W-Q_SIZE){1'b1}}, Q_MIN};

  function automatic sat_res_t sat_q(input logic signed [ACC_W-1:0] w);
    sat_res_t r;
    r.sat = 1'b0;
    r.q   = w[Q_SIZE-1:0];
    if (w > ACC_QMAX) begin
      r.sat = 1'b1;
      r.q   = Q_MAX;
    end else if (w < ACC_QMIN) begin
      r.sat = 1'b1;
      r.q   = Q_MIN;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwl_lut_bank.sv
// Simple dual-port coefficient RAM: one write port, one enabled synchronous read
// port. A same-address read and write in one cycle returns the old entry.
module pwl_lut_bank
  import pwl_activation_pipe_pkg::*;
#(
  parameter int ADDR_W = ACT_BANK_BITS + ACT_SEG_BITS
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  act_entry_t        wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output act_entry_t        rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  act_entry_t mem_q [DEPTH];
  act_entry_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pwl_activation_pipe.sv
// Multi-lane pipelined piecewise-linear activation: fx = slope[seg]*x + icpt[seg],
// with rounding, saturation, per-beat bypass and valid/ready backpressure.
module pwl_activation_pipe
  import pwl_activation_pipe_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int SEG_BITS  = ACT_SEG_BITS,
  parameter int BANK_BITS = ACT_BANK_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [BANK_BITS-1:0]      cfg_bank,
  input  logic [SEG_BITS-1:0]       cfg_seg,
  input  q_t                        cfg_slope,
  input  q_t                        cfg_icpt,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*Q_SIZE-1:0]   in_data,
  input  logic [BANK_BITS-1:0]      in_bank,
  input  logic                      in_bypass,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*Q_SIZE-1:0]   out_data,
  output logic [LANES-1:0]          out_sat
);

  localparam int DATA_W = Q_SIZE;
  localparam int ADDR_W = BANK_BITS + SEG_BITS;
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (Q_FRAC - 1);

  function automatic logic signed [ACC_W-1:0] round_q(input logic signed [2*DATA_W-1:0] p);
    logic signed [ACC_W-1:0] w;
    w = {p[2*DATA_W-1], p} + RND_HALF;
    return w >>> Q_FRAC;
  endfunction

  function automatic sat_res_t lane_calc(input q_t x, input act_entry_t e);
    logic signed [2*DATA_W-1:0] xw;
    logic signed [2*DATA_W-1:0] sw;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    icw;
    xw   = {{DATA_W{x[DATA_W-1]}}, x};
    sw   = {{DATA_W{e.slope[DATA_W-1]}}, e.slope};
    prod = sw * xw;
    icw  = {{(ACC_W-DATA_W){e.icpt[DATA_W-1]}}, e.icpt};
    return sat_q(round_q(prod) + icw);
  endfunction

  logic                      adv;
  logic                      vld_p0, vld_p1;
  logic [LANES*DATA_W-1:0]   x_p0, x_p1;
  logic [BANK_BITS-1:0]      bank_p0;
  logic                      byp_p0, byp_p1;
  logic [ADDR_W-1:0]         raddr [LANES];
  act_entry_t                lut_p1 [LANES];
  act_entry_t                wentry;
  sat_res_t                  lane_res [LANES];
  logic                      out_valid_q;
  logic [LANES*DATA_W-1:0]   out_data_q, out_data_d;
  logic [LANES-1:0]          out_sat_q, out_sat_d;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign wentry   = '{slope: cfg_slope, icpt: cfg_icpt};

  // S1: capture x, bank, bypass
  always_ff @(posedge clk) begin
    if (rst)      vld_p0 <= 1'b0;
    else if (adv) vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      x_p0    <= in_data;
      bank_p0 <= in_bank;
      byp_p0  <= in_bypass;
    end
  end

  // Segment index is the raw top bits of x, sign bit included.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      raddr[i] = {bank_p0, x_p0[i*DATA_W + DATA_W - 1 -: SEG_BITS]};
    end
  end

  // S2: LUT read issued from S1 registers; LUT output lands alongside x_p1
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pwl_lut_bank #(.ADDR_W(ADDR_W)) u_lut (
      .clk_i   (clk),
      .we_i    (cfg_we),
      .waddr_i ({cfg_bank, cfg_seg}),
      .wdata_i (wentry),
      .re_i    (adv),
      .raddr_i (raddr[g]),
      .rdata_o (lut_p1[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)      vld_p1 <= 1'b0;
    else if (adv) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      x_p1   <= x_p0;
      byp_p1 <= byp_p0;
    end
  end

  // S3: multiply, round, add intercept, saturate
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_res[i] = lane_calc(q_t'(x_p1[i*DATA_W +: DATA_W]), lut_p1[i]);
    end
  end

  always_comb begin
    out_data_d = x_p1;
    out_sat_d  = '0;
    if (!byp_p1) begin
      for (int i = 0; i < LANES; i++) begin
        out_data_d[i*DATA_W +: DATA_W] = lane_res[i].q;
        out_sat_d[i]                   = lane_res[i].sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else if (adv) begin
      out_valid_q <= vld_p1;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: doc/pwl_activation_pipe.md
Name: pwl_activation_pipe

Overview:
- Multi-lane, pipelined piecewise-linear activation unit: fx = slope[seg]*x + icpt[seg], with segment chosen by the top bits of x.
- Successor to the single-lane combinational LUT activation. Adds parametrised lanes, segment count and function banks, valid/ready backpressure, rounding, saturation, and a per-transaction bypass.
- Sits between the neuron accumulator output and the layer writeback buffer.

Parameters:
- Q_INT, 8, integer bits of the signed fixed-point format (sign included)
- Q_FRAC, 8, fractional bits; Q_SIZE = Q_INT+Q_FRAC
- LANES, 4, parallel channels sharing one bank select and one handshake
- SEG_BITS, 4, segment index width; 2**SEG_BITS segments per bank
- BANK_BITS, 2, function-select width; 2**BANK_BITS banks

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  LUT write strobe
- cfg_bank  in  BANK_BITS  bank to write
- cfg_seg  in  SEG_BITS  segment to write
- cfg_slope  in  Q_SIZE  signed slope, Q format
- cfg_icpt  in  Q_SIZE  signed intercept, Q format
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts a beat this cycle
- in_data  in  LANES*Q_SIZE  lane i at bits [i*Q_SIZE +: Q_SIZE]
- in_bank  in  BANK_BITS  function select for this beat
- in_bypass  in  1  pass x through unchanged
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*Q_SIZE  results, same lane packing as in_data
- out_sat  out  LANES  per-lane saturation flag for this beat

Behaviour:
- Reset: all stage valid bits cleared; out_valid=0, out_data=0, out_sat=0. LUT contents are not reset. Reset mid-operation drops all in-flight beats.
- Advance: adv = !out_valid || out_ready. in_ready = adv (combinational). A beat is accepted when in_valid && in_ready.
- The whole pipeline freezes when adv=0. Stage registers and the LUT read-enable are gated by adv, so stalled data is never lost or re-read.
- Pipeline:
  - S1 registers x, bank and bypass, then issues the synchronous LUT read at address {bank, x[Q_SIZE-1 -: SEG_BITS]}. The index is the raw top bits, sign bit included.
  - S2 holds the LUT output. Multiply p = slope*x is signed, 2*Q_SIZE bits.
  - S3 computes r = (p + 2**(Q_FRAC-1)) >>> Q_FRAC (round half up), adds sign-extended icpt, and saturates to [-2**(Q_SIZE-1), 2**(Q_SIZE-1)-1].
  - Latency is 3 cycles from acceptance to out_valid when no stall occurs. Throughput is 1 beat/cycle.
- out_sat[i]=1 iff lane i clamped in S3.
- Bypass: out_data = x, out_sat = 0, same latency and ordering as a computed beat.
- LUT: one copy per lane, all copies written identically. Each entry holds {slope, icpt}.
- cfg_we writes in one cycle. A read and write to the same address in the same cycle returns the old entry. Reads issued in any later cycle see the new entry. cfg writes are never blocked by backpressure.
- Out-of-order output never occurs. Beats leave in acceptance order.

Decomposition:
- The shared definitions package holds:
  - Q_INT, Q_FRAC, Q_SIZE, ACT_SEG_BITS, ACT_BANK_BITS as package constants.
  - typedef q_t (signed Q_SIZE).
  - typedef act_entry_t (packed struct {q_t slope; q_t icpt;}).
  - function sat_q (wide signed to q_t plus sat flag).
- One sub-module, pwl_lut_bank: a simple dual-port RAM, depth 2**(BANK_BITS+SEG_BITS), width act_entry_t. It has one write port, one read port with read enable, and synchronous read. It is instantiated LANES times.

Test Plan:
- Load bank0 seg0 slope=0x0080 (0.5), icpt=0x0040 (0.25). Send all lanes x=0x0200 (2.0), bank0, out_ready=1 -> out_data lanes=0x0140, out_sat=0, out_valid exactly 3 cycles after acceptance.
- Bank0 seg0 slope=0xFF00 (-1.0), icpt=0. Send x=0x0F00 -> 0xF100. Lane 1 x=0x0001, slope 0x0080 -> round gives 0x0001 (0.5 LSB rounds up).
- Saturation: bank1 seg0 slope=0x7FFF, x=0x0F00 -> 0x7FFF, sat=1. Bank1 seg15 slope=0x7FFF, x=0xF000 -> 0x8000, sat=1. Other lanes with x=0 -> 0x0000 plus the seg0 icpt, sat=0.
- Backpressure: stream 8 beats with distinct values, out_ready toggled 1,0,0,1,0,1... -> in_ready tracks adv, no beat lost, duplicated or reordered, and out_data stays stable while out_valid && !out_ready.
- Bypass and banks: alternate in_bypass and in_bank each beat -> bypass beats return x unchanged with sat=0. Others use the selected bank's entry. A cfg_we to the in-use entry in the same cycle as the S1 read yields the old value, while the next beat yields the new value.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight -> out_valid=0, out_data=0, out_sat=0 the next cycle. No stale beat appears afterwards. LUT entries loaded before reset remain usable.
